// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - sequenced ALU with start/busy/done handshake and registered result
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier for OP=101.
module alu_seq_unit #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       OP,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] R,
   output logic             carry,
   output logic             alu_flag
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, r_q;
   logic [2:0]       op_q;
   logic             busy_q, done_q, carry_q, flag_q;

   logic [WIDTH:0]   sum_w, diff_w;
   logic [WIDTH-1:0] exec_r_d;
   logic             exec_c_d;

   always_comb begin
      sum_w    = {1'b0, a_q} + {1'b0, b_q};
      diff_w   = {1'b0, a_q} - {1'b0, b_q};
      exec_r_d = '0;
      exec_c_d = 1'b0;
      case (op_q)
         3'b000: begin exec_r_d = sum_w[WIDTH-1:0];  exec_c_d = sum_w[WIDTH];  end
         3'b001: begin exec_r_d = diff_w[WIDTH-1:0]; exec_c_d = diff_w[WIDTH]; end
         3'b010: exec_r_d = a_q & b_q;
         3'b011: exec_r_d = a_q | b_q;
         3'b100: exec_r_d = a_q ^ b_q;
         default: ;
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   localparam int CW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH:0]     part_w;

   // Right-shifting multiplier: low half starts as B and is consumed LSB first.
   always_comb begin
      part_w = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
      acc_d  = {part_w, acc_q[WIDTH-1:1]};
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         r_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         carry_q <= 1'b0;
         flag_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         acc_q   <= '0;
         cnt_q   <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            // DONE doubles as an accept slot so back-to-back ops issue every 2 cycles.
            S_IDLE, S_DONE: begin
               if (start) begin
                  a_q    <= A;
                  b_q    <= B;
                  op_q   <= OP;
                  busy_q <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
                  if (OP == 3'b101) begin
                     acc_q   <= {{WIDTH{1'b0}}, B};
                     cnt_q   <= '0;
                     state_q <= S_MUL;
                  end else begin
                     state_q <= S_EXEC;
                  end
`else
                  state_q <= S_EXEC;
`endif
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_EXEC: begin
               r_q     <= exec_r_d;
               carry_q <= exec_c_d;
               flag_q  <= |exec_r_d;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  r_q     <= acc_d[WIDTH-1:0];
                  carry_q <= |acc_d[2*WIDTH-1:WIDTH];
                  flag_q  <= |acc_d[WIDTH-1:0];
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
`endif
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign R        = r_q;
   assign carry    = carry_q;
   assign alu_flag = flag_q;

endmodule
